// File: rtl/vdg_line_fetcher.sv
// ---------------------------------------------------------------------------
// vdg_line_fetcher
//
// Fetches one display row of video RAM per HSYNC into a line buffer. The
// pixel side reads that buffer by byte index. The row base address and the
// row-repeat count advance per line according to the addressing mode. The
// mode is latched at the start of each frame.
//
// Each byte is fetched by driving VDG_address for FETCH_LAT cycles: HOLD for
// FETCH_LAT-1 cycles, then CAPTURE for one cycle, in which VDG_data is written
// into the back bank.
//
// Optional feature macro: VDG_DOUBLE_BUFFER_EN
//   defined   : two 32-byte banks. Each HSYNC swaps front and back; rd_data
//               reads the front bank and fetches write the back bank.
//   undefined : one shared 32-byte bank. rd_data reads the bank being written,
//               and HSYNC only updates line_valid.
//
// Parameters
//   FETCH_LAT   cycles each address is held before the data is captured (2..15)
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   HSYNC       line sync, rising edge starts a line fetch
//   FSYNC       frame sync, rising edge restarts the frame and latches mode
//   mode        V2..V0 addressing mode, sampled only at the FSYNC rising edge
//   VDG_address video RAM byte address to the memory mapper (registered)
//   VDG_data    byte returned for VDG_address
//   rd_index    pixel-side byte index into the front bank
//   rd_data     combinational read of front bank[rd_index]
//   line_valid  front bank holds a fully fetched line (registered)
//   overrun     sticky: an HSYNC edge arrived while a fetch was in progress
// ---------------------------------------------------------------------------
module vdg_line_fetcher #(
    parameter int unsigned FETCH_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSYNC,
    input  logic        FSYNC,
    input  logic [2:0]  mode,
    output logic [12:0] VDG_address,
    input  logic [7:0]  VDG_data,
    input  logic [4:0]  rd_index,
    output logic [7:0]  rd_data,
    output logic        line_valid,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // The hold counter runs 0..FETCH_LAT-2, which gives FETCH_LAT-1 HOLD cycles
    // before the single CAPTURE cycle.
    localparam logic [3:0] HOLD_LAST = 4'(FETCH_LAT - 2);

    // Bytes per row for each addressing mode.
    function automatic logic [5:0] mode_bpr(input logic [2:0] m);
        logic [5:0] b;
        case (m)
            3'd1, 3'd3, 3'd5: b = 6'd16;
            default:          b = 6'd32;
        endcase
        return b;
    endfunction

    // Number of scan lines that show the same row.
    function automatic logic [3:0] mode_repeat(input logic [2:0] m);
        logic [3:0] r;
        case (m)
            3'd0:       r = 4'd12;
            3'd1, 3'd2: r = 4'd3;
            3'd3, 3'd4: r = 4'd2;
            default:    r = 4'd1;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    state_e      state_q,         state_d;
    logic [3:0]  hold_cnt_q,      hold_cnt_d;
    logic [4:0]  byte_idx_q,      byte_idx_d;
    logic [12:0] fetch_base_q,    fetch_base_d;
    logic [12:0] addr_q,          addr_d;
    logic [12:0] row_base_q,      row_base_d;
    logic [3:0]  rep_q,           rep_d;
    logic [2:0]  mode_q,          mode_d;
    logic        line_valid_q,    line_valid_d;
    logic        overrun_q,       overrun_d;
    logic        back_complete_q, back_complete_d;
    logic        hsync_q;
    logic        fsync_q;

    // ------------------------------------------------------ combinational
    logic        hsync_edge_s;
    logic        fsync_edge_s;
    logic [2:0]  eff_mode_s;
    logic [12:0] eff_row_s;
    logic [3:0]  eff_rep_s;
    logic        eff_busy_s;
    logic [5:0]  eff_bpr_s;
    logic [3:0]  eff_repeat_s;
    logic [5:0]  cur_bpr_s;
    logic        last_byte_s;
    logic        bank_we_s;

    // Edge detection, and the effective frame context for this cycle's HSYNC.
    always_comb begin
        hsync_edge_s = HSYNC & ~hsync_q;
        fsync_edge_s = FSYNC & ~fsync_q;
        // A coincident FSYNC edge is applied first, so HSYNC sees the freshly
        // reset counters, the new mode and an aborted (idle) fetch.
        eff_mode_s   = fsync_edge_s ? mode  : mode_q;
        eff_row_s    = fsync_edge_s ? 13'd0 : row_base_q;
        eff_rep_s    = fsync_edge_s ? 4'd0  : rep_q;
        eff_busy_s   = (~fsync_edge_s) & (state_q != ST_IDLE);
        eff_bpr_s    = mode_bpr(eff_mode_s);
        eff_repeat_s = mode_repeat(eff_mode_s);
        cur_bpr_s    = mode_bpr(mode_q);
        last_byte_s  = ({1'b0, byte_idx_q} == (cur_bpr_s - 6'd1));
    end

    // Next-state logic for the fetch FSM, the row counters and the status flags.
    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        byte_idx_d      = byte_idx_q;
        fetch_base_d    = fetch_base_q;
        addr_d          = addr_q;
        row_base_d      = row_base_q;
        rep_d           = rep_q;
        mode_d          = mode_q;
        line_valid_d    = line_valid_q;
        overrun_d       = overrun_q;
        back_complete_d = back_complete_q;
        bank_we_s       = 1'b0;

        if (hsync_edge_s) begin
            // Start a new line. An interrupted fetch leaves an incomplete
            // line, which must not be shown as valid.
            if (eff_busy_s) begin
                overrun_d    = 1'b1;
                line_valid_d = 1'b0;
            end else begin
                line_valid_d = back_complete_q;
            end
            back_complete_d = 1'b0;
            mode_d          = eff_mode_s;
            state_d         = ST_HOLD;
            hold_cnt_d      = 4'd0;
            byte_idx_d      = 5'd0;
            fetch_base_d    = eff_row_s;
            addr_d          = eff_row_s;
            // The fetch uses the pre-update row base; the counters advance afterwards.
            if (eff_rep_s == (eff_repeat_s - 4'd1)) begin
                rep_d      = 4'd0;
                row_base_d = eff_row_s + {7'd0, eff_bpr_s};
            end else begin
                rep_d      = eff_rep_s + 4'd1;
                row_base_d = eff_row_s;
            end
        end else if (fsync_edge_s) begin
            mode_d     = mode;
            row_base_d = 13'd0;
            rep_d      = 4'd0;
            state_d    = ST_IDLE;
            hold_cnt_d = 4'd0;
            byte_idx_d = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    bank_we_s = 1'b1;
                    if (last_byte_s) begin
                        // VDG_address is left on the last byte while idle.
                        back_complete_d = 1'b1;
                        state_d         = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 5'd1;
                        addr_d     = fetch_base_q + {8'd0, byte_idx_q} + 13'd1;
                        hold_cnt_d = 4'd0;
                        state_d    = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register for the FSM, counters, flags and sync edge detectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            hold_cnt_q      <= 4'd0;
            byte_idx_q      <= 5'd0;
            fetch_base_q    <= 13'd0;
            addr_q          <= 13'd0;
            row_base_q      <= 13'd0;
            rep_q           <= 4'd0;
            mode_q          <= 3'd0;
            line_valid_q    <= 1'b0;
            overrun_q       <= 1'b0;
            back_complete_q <= 1'b0;
            hsync_q         <= 1'b0;
            fsync_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            byte_idx_q      <= byte_idx_d;
            fetch_base_q    <= fetch_base_d;
            addr_q          <= addr_d;
            row_base_q      <= row_base_d;
            rep_q           <= rep_d;
            mode_q          <= mode_d;
            line_valid_q    <= line_valid_d;
            overrun_q       <= overrun_d;
            back_complete_q <= back_complete_d;
            hsync_q         <= HSYNC;
            fsync_q         <= FSYNC;
        end
    end

`ifdef VDG_DOUBLE_BUFFER_EN
    logic [7:0] bank_q [0:1][0:31];
    logic       front_sel_q;
    logic       front_sel_d;

    // Front/back selection flips on every line start.
    always_comb begin
        if (hsync_edge_s) begin
            front_sel_d = ~front_sel_q;
        end else begin
            front_sel_d = front_sel_q;
        end
    end

    // Bank select register.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_sel_q <= 1'b0;
        end else begin
            front_sel_q <= front_sel_d;
        end
    end

    // Line buffer storage: captures go to the back bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 32; i++) begin
                    bank_q[b][i] <= 8'h00;
                end
            end
        end else if (bank_we_s) begin
            bank_q[~front_sel_q][byte_idx_q] <= VDG_data;
        end
    end

    assign rd_data = bank_q[front_sel_q][rd_index];
`else
    logic [7:0] bank_q [0:31];

    // Shared line buffer storage: captures and pixel reads use the same bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else if (bank_we_s) begin
            bank_q[byte_idx_q] <= VDG_data;
        end
    end

    assign rd_data = bank_q[rd_index];
`endif

    assign VDG_address = addr_q;
    assign line_valid  = line_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_vdg_line_fetcher.sv
// Self-checking bench for vdg_line_fetcher (default single-bank build).
// Video RAM is modelled as a function of the address plus a random key.
// Expected addresses, row bases and buffer contents come from plain
// arithmetic on the mode tables.
module tb_vdg_line_fetcher;
    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSYNC;
    logic        FSYNC;
    logic [2:0]  mode;
    logic [12:0] VDG_address;
    logic [7:0]  VDG_data;
    logic [4:0]  rd_index;
    logic [7:0]  rd_data;
    logic        line_valid;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  key = 8'h00;
    logic [12:0] trace [$];
    logic [7:0]  bank_m [32];

    vdg_line_fetcher #(.FETCH_LAT(FL)) dut (
        .clk(clk), .rst(rst), .HSYNC(HSYNC), .FSYNC(FSYNC), .mode(mode),
        .VDG_address(VDG_address), .VDG_data(VDG_data),
        .rd_index(rd_index), .rd_data(rd_data),
        .line_valid(line_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Memory: low byte of the address, mixed with the high bits and a key.
    assign VDG_data = VDG_address[7:0] ^ {VDG_address[12:8], 3'b000} ^ key;

    function automatic logic [7:0] mem_byte(input logic [12:0] a);
        return a[7:0] ^ {a[12:8], 3'b000} ^ key;
    endfunction

    function automatic int bpr_of(input logic [2:0] m);
        if (m == 3'd1 || m == 3'd3 || m == 3'd5) return 16;
        return 32;
    endfunction

    function automatic int rep_of(input logic [2:0] m);
        case (m)
            3'd0:       return 12;
            3'd1, 3'd2: return 3;
            3'd3, 3'd4: return 2;
            default:    return 1;
        endcase
    endfunction

    // Row base for the line-th HSYNC of a frame (0-based).
    function automatic logic [12:0] line_base(input logic [2:0] m, input int line);
        int v;
        v = (line / rep_of(m)) * bpr_of(m);
        return v[12:0];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; HSYNC = 1'b0; FSYNC = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) bank_m[i] = 8'h00;
    endtask

    task automatic frame(input logic [2:0] m);
        mode = m; FSYNC = 1'b1;
        step();
        FSYNC = 1'b0;
        step();
    endtask

    // Raise HSYNC for one clock; returns at the first negedge after the edge takes effect.
    task automatic hsync();
        HSYNC = 1'b1;
        step();
        HSYNC = 1'b0;
    endtask

    // Record VDG_address once per cycle, starting with the current negedge.
    task automatic capture_trace(input int n);
        trace.delete();
        for (int k = 0; k < n; k++) begin
            trace.push_back(VDG_address);
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; HSYNC = 1'b0; FSYNC = 1'b0; mode = 3'd0; rd_index = 5'd0;
        step(); step(); step();
        rst = 1'b0;
        step();
        checks++; if (VDG_address !== 13'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", VDG_address); end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid: got %b expected 0", line_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        for (int i = 0; i < 32; i++) begin
            rd_index = 5'(i); #1;
            checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_bank[%0d]: got %h expected 00", i, rd_data); end
        end
        for (int i = 0; i < 5; i++) step();
        checks++; if (VDG_address !== 13'h0000) begin errors++; $display("FAIL reset_idle_addr: got %h expected 0000", VDG_address); end
    endtask

    task automatic test_mode6_line();
        logic [12:0] exp_a;
        do_reset(); key = 8'h00;
        frame(3'd6);
        hsync();
        capture_trace(32 * FL);
        for (int k = 0; k < 32 * FL; k++) begin
            exp_a = 13'(k / FL);
            checks++; if (trace[k] !== exp_a) begin errors++; $display("FAIL m6_line0_addr[%0d]: got %h expected %h", k, trace[k], exp_a); end
        end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL m6_first_line_valid: got %b expected 0", line_valid); end
        step(); step(); step();
        checks++; if (VDG_address !== 13'h001F) begin errors++; $display("FAIL m6_idle_hold_addr: got %h expected 001f", VDG_address); end
        for (int i = 0; i < 32; i++) begin
            rd_index = 5'(i); #1;
            checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL m6_bank[%0d]: got %h expected %h", i, rd_data, 8'(i)); end
        end
        hsync();
        checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL m6_second_line_valid: got %b expected 1", line_valid); end
        rd_index = 5'd5; #1;
        checks++; if (rd_data !== 8'h05) begin errors++; $display("FAIL m6_rd5: got %h expected 05", rd_data); end
        capture_trace(32 * FL);
        for (int k = 0; k < 32 * FL; k++) begin
            exp_a = 13'h020 + 13'(k / FL);
            checks++; if (trace[k] !== exp_a) begin errors++; $display("FAIL m6_line1_addr[%0d]: got %h expected %h", k, trace[k], exp_a); end
        end
    endtask

    task automatic test_row_repeat();
        logic [12:0] spec_base [4];
        logic [12:0] exp_a;
        logic [12:0] b;
        spec_base[0] = 13'h000; spec_base[1] = 13'h000; spec_base[2] = 13'h000; spec_base[3] = 13'h010;
        do_reset(); key = 8'($urandom);
        frame(3'd1);
        mode = 3'($urandom);
        for (int l = 0; l < 4; l++) begin
            b = line_base(3'd1, l);
            hsync();
            if (l > 0) begin
                checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL m1_line_valid[%0d]: got %b expected 1", l, line_valid); end
            end
            capture_trace(16 * FL);
            checks++; if (trace[0] !== spec_base[l]) begin errors++; $display("FAIL m1_base[%0d]: got %h expected %h", l, trace[0], spec_base[l]); end
            for (int k = 0; k < 16 * FL; k++) begin
                exp_a = b + 13'(k / FL);
                checks++; if (trace[k] !== exp_a) begin errors++; $display("FAIL m1_addr[%0d][%0d]: got %h expected %h", l, k, trace[k], exp_a); end
            end
            for (int i = 0; i < 32; i++) begin
                rd_index = 5'(i); #1;
                exp_a = b + 13'(i);
                if (i < 16) begin
                    checks++; if (rd_data !== mem_byte(exp_a)) begin errors++; $display("FAIL m1_bank[%0d][%0d]: got %h expected %h", l, i, rd_data, mem_byte(exp_a)); end
                end else begin
                    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL m1_unwritten[%0d][%0d]: got %h expected 00", l, i, rd_data); end
                end
            end
            for (int s = 0; s < 35; s++) step();
        end
    endtask

    task automatic test_wrap();
        logic [12:0] exp_a;
        do_reset(); key = 8'($urandom);
        frame(3'd6);
        // Fast HSYNCs only advance the row counter (each interrupts a fetch).
        for (int l = 0; l < 255; l++) begin
            HSYNC = 1'b1; step(); HSYNC = 1'b0; step();
        end
        hsync();
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL wrap_lv_after_overrun: got %b expected 0", line_valid); end
        capture_trace(32 * FL);
        for (int k = 0; k < 32 * FL; k++) begin
            exp_a = line_base(3'd6, 255) + 13'(k / FL);
            checks++; if (trace[k] !== exp_a) begin errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, trace[k], exp_a); end
        end
        step(); step();
        hsync();
        capture_trace(8);
        checks++; if (trace[0] !== 13'h0000) begin errors++; $display("FAIL wrap_next_base: got %h expected 0000", trace[0]); end
        checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL wrap_line_valid: got %b expected 1", line_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL wrap_overrun: got %b expected 1", overrun); end
    endtask

    task automatic test_overrun();
        logic [12:0] exp_a;
        do_reset(); key = 8'($urandom);
        frame(3'd6);
        hsync();
        capture_trace(40);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b expected 0", overrun); end
        hsync();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL ovr_line_valid: got %b expected 0", line_valid); end
        capture_trace(32 * FL);
        for (int k = 0; k < 32 * FL; k++) begin
            exp_a = 13'h020 + 13'(k / FL);
            checks++; if (trace[k] !== exp_a) begin errors++; $display("FAIL ovr_restart_addr[%0d]: got %h expected %h", k, trace[k], exp_a); end
        end
        for (int i = 0; i < 32; i++) begin
            rd_index = 5'(i); #1;
            checks++; if (rd_data !== mem_byte(13'h020 + 13'(i))) begin errors++; $display("FAIL ovr_bank[%0d]: got %h expected %h", i, rd_data, mem_byte(13'h020 + 13'(i))); end
        end
        step(); step();
        hsync();
        checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL ovr_recover_lv: got %b expected 1", line_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        checks++; if (VDG_address !== 13'h040) begin errors++; $display("FAIL ovr_next_base: got %h expected 0040", VDG_address); end
    endtask

    task automatic test_reset_mid();
        do_reset(); key = 8'($urandom);
        frame(3'd6);
        hsync();
        capture_trace(32 * FL);
        step(); step();
        hsync();
        checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL rstmid_lv_before: got %b expected 1", line_valid); end
        // CAPTURE of byte 10 occupies the 44th cycle of the fetch.
        capture_trace(43);
        checks++; if (VDG_address !== 13'h02A) begin errors++; $display("FAIL rstmid_addr_before: got %h expected 002a", VDG_address); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (VDG_address !== 13'h0000) begin errors++; $display("FAIL rstmid_addr: got %h expected 0000", VDG_address); end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL rstmid_lv: got %b expected 0", line_valid); end
        for (int i = 0; i < 32; i++) begin
            rd_index = 5'(i); #1;
            checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_bank[%0d]: got %h expected 00", i, rd_data); end
        end
        for (int s = 0; s < 6; s++) step();
        checks++; if (VDG_address !== 13'h0000) begin errors++; $display("FAIL rstmid_idle: got %h expected 0000", VDG_address); end
    endtask

    task automatic test_fsync_hsync();
        logic [12:0] exp_a;
        do_reset(); key = 8'($urandom);
        frame(3'd6);
        for (int l = 0; l < 3; l++) begin
            hsync(); capture_trace(32 * FL); step(); step();
        end
        mode = 3'd2; FSYNC = 1'b1; HSYNC = 1'b1;
        step();
        FSYNC = 1'b0; HSYNC = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coinc_overrun: got %b expected 0", overrun); end
        for (int l = 0; l < 4; l++) begin
            if (l > 0) hsync();
            capture_trace(32 * FL);
            for (int k = 0; k < 32 * FL; k++) begin
                exp_a = line_base(3'd2, l) + 13'(k / FL);
                checks++; if (trace[k] !== exp_a) begin errors++; $display("FAIL coinc_addr[%0d][%0d]: got %h expected %h", l, k, trace[k], exp_a); end
            end
            step(); step();
        end
    endtask

    task automatic test_random_modes();
        logic [2:0]  m;
        logic [12:0] b;
        logic [12:0] exp_a;
        int          n;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            m = 3'($urandom_range(0, 7));
            key = 8'($urandom);
            frame(m);
            mode = 3'($urandom);
            n = rep_of(m) + 2;
            for (int l = 0; l < n; l++) begin
                b = line_base(m, l);
                hsync();
                if (l > 0) begin
                    checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL rnd_lv[%0d][%0d]: got %b expected 1", it, l, line_valid); end
                end
                capture_trace(bpr_of(m) * FL);
                for (int k = 0; k < bpr_of(m) * FL; k++) begin
                    exp_a = b + 13'(k / FL);
                    checks++; if (trace[k] !== exp_a) begin errors++; $display("FAIL rnd_addr[%0d][%0d][%0d]: got %h expected %h", it, l, k, trace[k], exp_a); end
                end
                for (int i = 0; i < bpr_of(m); i++) bank_m[i] = mem_byte(b + 13'(i));
                for (int i = 0; i < 32; i++) begin
                    rd_index = 5'(i); #1;
                    checks++; if (rd_data !== bank_m[i]) begin errors++; $display("FAIL rnd_bank[%0d][%0d][%0d]: got %h expected %h", it, l, i, rd_data, bank_m[i]); end
                end
                for (int s = 0; s < int'($urandom_range(1, 6)); s++) step();
            end
        end
    endtask

    initial begin
        rst = 1'b1; HSYNC = 1'b0; FSYNC = 1'b0; mode = 3'd0; rd_index = 5'd0;
        test_reset();
        test_mode6_line();
        test_row_repeat();
        test_wrap();
        test_overrun();
        test_reset_mid();
        test_fsync_hsync();
        test_random_modes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
